// File: rtl/pipelined_data_path.sv
// 3-stage D/E/W integer datapath with register file and ALU; E->W forwarding when DP_FORWARD_EN is defined.
// Latency: an instruction accepted at cycle t is in E at t+1 and in W (writeback, memory) at t+2.
// Backpressure: in_ready = ~stall & ~hazard; stall freezes every stage, hazard inserts one bubble.
module pipelined_data_path #(
    parameter int W     = 5,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             stall,
    input  logic [W-1:0]     r_addr_A,
    input  logic [W-1:0]     r_addr_B,
    input  logic [W-1:0]     w_addr,
    input  logic [WIDTH-1:0] imm_ext,
    input  logic             alu_src,
    input  logic [2:0]       alu_control,
    input  logic             reg_write,
    input  logic             result_src,
    input  logic             mem_write,
    input  logic [WIDTH-1:0] read_data,
    output logic             zero,
    output logic             sign,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] write_data,
    output logic             mem_we,
    output logic [WIDTH-1:0] result,
    output logic             wb_valid
);
    localparam int NREG = 2 ** W;
    localparam int SH   = $clog2(WIDTH);

    logic [WIDTH-1:0] rf_q [NREG];

    // E stage
    logic             valid_e_q, src_e_q, rw_e_q, rsrc_e_q, mw_e_q;
    logic [W-1:0]     rd_e_q;
    logic [WIDTH-1:0] a_e_q, b_e_q, imm_e_q;
    logic [2:0]       ctl_e_q;

    // W stage
    logic             valid_w_q, rw_w_q, rsrc_w_q, mw_w_q;
    logic [W-1:0]     rd_w_q;
    logic [WIDTH-1:0] alu_w_q, wd_w_q;

    logic             hazard, accept, wb_we;
    logic [WIDTH-1:0] rd_a, rd_b, op_a, op_b, alu_b, alu_y;

    assign result = (valid_w_q && rsrc_w_q) ? read_data : alu_w_q;
    assign wb_we  = valid_w_q & rw_w_q & ~stall & (rd_w_q != '0);

    // Write-through read: the value being written back this cycle wins over the array.
    always_comb begin
        rd_a = rf_q[r_addr_A];
        rd_b = rf_q[r_addr_B];
        if (wb_we && rd_w_q == r_addr_A) rd_a = result;
        if (wb_we && rd_w_q == r_addr_B) rd_b = result;
        if (r_addr_A == '0) rd_a = '0;
        if (r_addr_B == '0) rd_b = '0;
    end

`ifdef DP_FORWARD_EN
    logic [W-1:0] rs1_e_q, rs2_e_q;
    logic         fwd_ok;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            rs1_e_q <= '0;
            rs2_e_q <= '0;
        end else if (!stall) begin
            rs1_e_q <= r_addr_A;
            rs2_e_q <= r_addr_B;
        end
    end

    assign fwd_ok = valid_w_q & rw_w_q & (rd_w_q != '0);
    assign op_a   = (fwd_ok && rd_w_q == rs1_e_q) ? result : a_e_q;
    assign op_b   = (fwd_ok && rd_w_q == rs2_e_q) ? result : b_e_q;
    assign hazard = 1'b0;
`else
    assign op_a   = a_e_q;
    assign op_b   = b_e_q;
    assign hazard = valid_e_q & rw_e_q & (rd_e_q != '0) &
                    ((rd_e_q == r_addr_A) | (rd_e_q == r_addr_B));
`endif

    assign in_ready = ~stall & ~hazard;
    assign accept   = in_valid & in_ready;

    assign alu_b = src_e_q ? imm_e_q : op_b;

    always_comb begin
        alu_y = '0;
        case (ctl_e_q)
            3'b000:  alu_y = op_a + alu_b;
            3'b001:  alu_y = op_a - alu_b;
            3'b010:  alu_y = op_a & alu_b;
            3'b011:  alu_y = op_a | alu_b;
            3'b100:  alu_y = op_a ^ alu_b;
            3'b101:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(alu_b))};
            3'b110:  alu_y = op_a << alu_b[SH-1:0];
            default: alu_y = op_a >> alu_b[SH-1:0];
        endcase
    end

    assign zero       = (alu_y == '0);
    assign sign       = alu_y[WIDTH-1];
    assign alu_result = alu_w_q;
    assign write_data = wd_w_q;
    assign mem_we     = valid_w_q & mw_w_q & ~stall;
    assign wb_valid   = valid_w_q;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            valid_e_q <= 1'b0;
            src_e_q   <= 1'b0;
            rw_e_q    <= 1'b0;
            rsrc_e_q  <= 1'b0;
            mw_e_q    <= 1'b0;
            rd_e_q    <= '0;
            a_e_q     <= '0;
            b_e_q     <= '0;
            imm_e_q   <= '0;
            ctl_e_q   <= '0;
            valid_w_q <= 1'b0;
            rw_w_q    <= 1'b0;
            rsrc_w_q  <= 1'b0;
            mw_w_q    <= 1'b0;
            rd_w_q    <= '0;
            alu_w_q   <= '0;
            wd_w_q    <= '0;
        end else if (!stall) begin
            valid_e_q <= accept;
            src_e_q   <= alu_src;
            rw_e_q    <= reg_write;
            rsrc_e_q  <= result_src;
            mw_e_q    <= mem_write;
            rd_e_q    <= w_addr;
            a_e_q     <= rd_a;
            b_e_q     <= rd_b;
            imm_e_q   <= imm_ext;
            ctl_e_q   <= alu_control;
            valid_w_q <= valid_e_q;
            rw_w_q    <= rw_e_q;
            rsrc_w_q  <= rsrc_e_q;
            mw_w_q    <= mw_e_q;
            rd_w_q    <= rd_e_q;
            alu_w_q   <= alu_y;
            wd_w_q    <= op_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (wb_we) begin
            rf_q[rd_w_q] <= result;
        end
    end
endmodule
